fab_clk_tick_gen: RTL and testbench
===================================

FAB_CLK_TICK_GEN -- requirements
Module: fab_clk_tick_gen

Interface
REQ-001 The block SHALL have parameter DIV_QUARTER, default 25, giving the FAB_CLK cycles per 0.25 us quarter-bit tick; legal range 2..255.
REQ-002 The block SHALL have parameter LOCK_STABLE, default 1024, giving the consecutive synchronized-lock cycles required before release; legal range 4..65535.
REQ-003 The block SHALL have parameter LOCK_IGNORE, default 1; when 1, the lock input is treated as constant 1.
REQ-004 FAB_CLK  input  1  fabric clock from the MSS CCC; the only clock.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 FAB_LOCK  input  1  CCC lock, asynchronous to FAB_CLK.
REQ-007 TICK_EN  input  1  tick generation enable, synchronous.
REQ-008 FAB_RESET  output  1  active-high synchronous reset for downstream fabric logic.
REQ-009 READY  output  1  high only in state RUN.
REQ-010 TICK_Q  output  1  one-cycle pulse every DIV_QUARTER cycles.
REQ-011 TICK_US  output  1  one-cycle pulse coincident with every 4th TICK_Q.
REQ-012 PHASE  output  2  quarter index within the current microsecond, 0..3.

Function
REQ-013 FAB_LOCK SHALL pass through a 2-flop synchronizer; lock_s is the 2nd stage. With LOCK_IGNORE=1, lock_s SHALL be forced to 1.
REQ-014 The FSM SHALL have exactly three states: WAIT_LOCK, STABILIZE, RUN.
REQ-015 WAIT_LOCK: stable counter held at 0; transition to STABILIZE when lock_s=1.
REQ-016 STABILIZE: stable counter increments each cycle lock_s=1; lock_s=0 returns to WAIT_LOCK with counter cleared; counter reaching LOCK_STABLE-1 with lock_s=1 transitions to RUN.
REQ-017 RUN: stay while lock_s=1; lock_s=0 returns to WAIT_LOCK on the next edge.
REQ-018 FAB_RESET SHALL be registered: 1 in every cycle where state is not RUN, and 0 starting one cycle after entry to RUN.
REQ-019 READY SHALL be registered and equal (state==RUN); it rises in the same cycle FAB_RESET falls.
REQ-020 The divider counter (8-bit) SHALL count 0..DIV_QUARTER-1 and wrap to 0; it runs only when READY=1 and TICK_EN=1, and holds its value otherwise.
REQ-021 TICK_Q SHALL pulse for one cycle when the divider counter wraps from DIV_QUARTER-1 to 0.
REQ-022 PHASE SHALL increment modulo 4 on each TICK_Q.
REQ-023 TICK_US SHALL pulse in the same cycle as the TICK_Q where PHASE goes from 3 to 0.
REQ-024 TICK_EN deassertion SHALL freeze the divider and PHASE with no tick emitted; reassertion SHALL resume from the frozen values.
REQ-025 Leaving RUN SHALL clear the divider, PHASE, TICK_Q and TICK_US in the same edge that clears READY.
REQ-026 Loss of lock SHALL take priority over a simultaneous divider wrap: no tick is emitted in that cycle.
REQ-027 From first lock_s=1 in WAIT_LOCK, READY SHALL rise exactly LOCK_STABLE+2 cycles later if lock_s stays high.

Reset
REQ-028 While RESET=1, the block SHALL be asynchronously in the following state: state=WAIT_LOCK; synchronizer flops, stable counter, divider and PHASE at 0; FAB_RESET=1; READY=0; TICK_Q=0; TICK_US=0.
REQ-029 After RESET deasserts, the FSM SHALL begin operation on the first FAB_CLK edge; no output glitches to FAB_RESET=0 before RUN.
REQ-030 Asserting RESET in any state, including mid-tick, SHALL immediately force the values of REQ-028.

Verification
REQ-031 Test 1: LOCK_IGNORE=1, LOCK_STABLE=4, RESET released -> READY rises on cycle 7 after release (per REQ-027 with lock_s=1 from cycle 1), FAB_RESET falls in the same cycle.
REQ-032 Test 2: DIV_QUARTER=25, TICK_EN=1, 400 cycles in RUN -> exactly 16 TICK_Q pulses 25 cycles apart, 4 TICK_US pulses 100 cycles apart, PHASE sequence 1,2,3,0 repeating.
REQ-033 Test 3: LOCK_IGNORE=0, FAB_LOCK dropped for 3 cycles during STABILIZE at count 500 -> return to WAIT_LOCK, counter restarts, READY only after a full 1024-cycle stable window.
REQ-034 Test 4: FAB_LOCK dropped in RUN on the cycle a wrap is due -> no TICK_Q, FAB_RESET=1 and READY=0 three cycles after the FAB_LOCK fall (2 synchronizer cycles + 1 register), PHASE=0.
REQ-035 Test 5: TICK_EN low for 10 cycles at divider=12, PHASE=2 -> no ticks, divider stays at 12; TICK_Q arrives 13 cycles after re-enable.
REQ-036 Test 6: RESET pulse mid-RUN, asynchronous to FAB_CLK -> all outputs take their REQ-028 values before the next FAB_CLK edge.

Source files
------------

// File: rtl/fab_clk_tick_gen.sv
// Fabric reset/ready sequencer with a quarter-microsecond tick divider.
// Release waits for a debounced CCC lock; ticks run only while READY is high.
`timescale 1ns/1ps

module fab_clk_tick_gen #(
  parameter int DIV_QUARTER = 25,
  parameter int LOCK_STABLE = 1024,
  parameter bit LOCK_IGNORE = 1'b1
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       FAB_LOCK,
  input  logic       TICK_EN,
  output logic       FAB_RESET,
  output logic       READY,
  output logic       TICK_Q,
  output logic       TICK_US,
  output logic [1:0] PHASE
);

  localparam logic [7:0]  DIV_LAST    = 8'(DIV_QUARTER - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] stable_cnt_reg, stable_cnt_next;
  logic [1:0]  sync_reg;
  logic        lock_s;
  logic        run_ok;

  logic        fab_reset_reg;
  logic        ready_reg;
  logic        tick_q_reg;
  logic        tick_us_reg;
  logic [1:0]  phase_reg;
  logic [7:0]  div_reg;

  // With the lock ignored, the second stage still leaves reset at 0 so the
  // release timing is identical to a lock that is high from the first edge.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg[0] <= FAB_LOCK;
      sync_reg[1] <= LOCK_IGNORE ? 1'b1 : sync_reg[0];
    end
  end

  assign lock_s = sync_reg[1];

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= WAIT_LOCK;
      stable_cnt_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      stable_cnt_reg <= stable_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stable_cnt_next = stable_cnt_reg;
    case (state_reg)
      WAIT_LOCK: begin
        stable_cnt_next = 16'd0;
        if (lock_s) state_next = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next      = WAIT_LOCK;
          stable_cnt_next = 16'd0;
        end else if (stable_cnt_reg == STABLE_LAST) begin
          state_next      = RUN;
          stable_cnt_next = 16'd0;
        end else begin
          stable_cnt_next = stable_cnt_reg + 16'd1;
        end
      end
      RUN: begin
        stable_cnt_next = 16'd0;
        if (!lock_s) state_next = WAIT_LOCK;
      end
      default: begin
        state_next      = WAIT_LOCK;
        stable_cnt_next = 16'd0;
      end
    endcase
  end

  // Qualifying with lock_s drops READY on the same edge the FSM leaves RUN,
  // which also lets a lock loss override a divider wrap due on that edge.
  assign run_ok = (state_reg == RUN) && lock_s;

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      fab_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
      tick_q_reg    <= 1'b0;
      tick_us_reg   <= 1'b0;
      phase_reg     <= 2'd0;
      div_reg       <= 8'd0;
    end else begin
      fab_reset_reg <= !run_ok;
      ready_reg     <= run_ok;
      if (!run_ok) begin
        tick_q_reg  <= 1'b0;
        tick_us_reg <= 1'b0;
        phase_reg   <= 2'd0;
        div_reg     <= 8'd0;
      end else if (ready_reg && TICK_EN) begin
        if (div_reg == DIV_LAST) begin
          div_reg     <= 8'd0;
          tick_q_reg  <= 1'b1;
          tick_us_reg <= (phase_reg == 2'd3);
          phase_reg   <= phase_reg + 2'd1;
        end else begin
          div_reg     <= div_reg + 8'd1;
          tick_q_reg  <= 1'b0;
          tick_us_reg <= 1'b0;
        end
      end else begin
        tick_q_reg  <= 1'b0;
        tick_us_reg <= 1'b0;
      end
    end
  end

  assign FAB_RESET = fab_reset_reg;
  assign READY     = ready_reg;
  assign TICK_Q    = tick_q_reg;
  assign TICK_US   = tick_us_reg;
  assign PHASE     = phase_reg;

endmodule

// File: tb/tb_fab_clk_tick_gen.sv
// Bench for fab_clk_tick_gen: dut_a ignores lock (short window), dut_b uses a
// real synchronized lock with the default 1024-cycle window.
`timescale 1ns/1ps

module tb_fab_clk_tick_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lock_a, en_a, fab_reset_a, ready_a, tick_q_a, tick_us_a;
  logic [1:0] phase_a;
  logic       rst_b, lock_b, en_b, fab_reset_b, ready_b, tick_q_b, tick_us_b;
  logic [1:0] phase_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int t1 = 0;

  typedef struct {
    int         at_edge;
    logic [1:0] phase;
    logic       us;
  } tick_t;

  tick_t exp_q[$];

  fab_clk_tick_gen #(.DIV_QUARTER(25), .LOCK_STABLE(4), .LOCK_IGNORE(1'b1)) dut_a (
    .FAB_CLK(clk), .RESET(rst_a), .FAB_LOCK(lock_a), .TICK_EN(en_a),
    .FAB_RESET(fab_reset_a), .READY(ready_a), .TICK_Q(tick_q_a),
    .TICK_US(tick_us_a), .PHASE(phase_a)
  );

  fab_clk_tick_gen #(.DIV_QUARTER(25), .LOCK_STABLE(1024), .LOCK_IGNORE(1'b0)) dut_b (
    .FAB_CLK(clk), .RESET(rst_b), .FAB_LOCK(lock_b), .TICK_EN(en_b),
    .FAB_RESET(fab_reset_b), .READY(ready_b), .TICK_Q(tick_q_b),
    .TICK_US(tick_us_b), .PHASE(phase_b)
  );

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    lock_a = 1'b0; lock_b = 1'b1;
    en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({fab_reset_a, ready_a, tick_q_a, tick_us_a, phase_a} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_a: {FAB_RESET,READY,TICK_Q,TICK_US,PHASE}=%b required 100000",
               {fab_reset_a, ready_a, tick_q_a, tick_us_a, phase_a});
    end
    checks++;
    if ({fab_reset_b, ready_b, tick_q_b, tick_us_b, phase_b} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_b: {FAB_RESET,READY,TICK_Q,TICK_US,PHASE}=%b required 100000",
               {fab_reset_b, ready_b, tick_q_b, tick_us_b, phase_b});
    end
  endtask

  // Lock ignored, window of 4: READY rises on the 7th edge after release.
  task automatic test_lock_ignore();
    @(negedge clk);
    rst_a = 1'b0;
    t0 = cyc;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (ready_a !== (n >= 7) || fab_reset_a !== (n < 7)) begin
        errors++;
        $display("FAIL lock_ignore edge %0d: READY=%b FAB_RESET=%b required READY=%b FAB_RESET=%b",
                 n, ready_a, fab_reset_a, (n >= 7), (n < 7));
      end
    end
  endtask

  task automatic test_ticks();
    tick_t e;
    for (int i = 1; i <= 16; i++) begin
      e.at_edge = 7 + 25 * i;
      e.phase   = 2'(i % 4);
      e.us      = (i % 4 == 0);
      exp_q.push_back(e);
    end
    while (cyc - t0 < 410) begin
      @(negedge clk);
      if (tick_us_a && !tick_q_a) begin
        checks++; errors++;
        $display("FAIL ticks_us_alone edge %0d: TICK_US=1 TICK_Q=0 required TICK_US only with TICK_Q", cyc - t0);
      end
      if (tick_q_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ticks_extra edge %0d: TICK_Q=1 required 0", cyc - t0);
        end else begin
          e = exp_q.pop_front();
          if (cyc - t0 !== e.at_edge || phase_a !== e.phase || tick_us_a !== e.us) begin
            errors++;
            $display("FAIL ticks edge %0d PHASE=%0d TICK_US=%b required edge %0d PHASE=%0d TICK_US=%b",
                     cyc - t0, phase_a, tick_us_a, e.at_edge, e.phase, e.us);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ticks_missing: %0d pending required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Freeze at divider=12, PHASE=2 (edge 469); the next tick comes 13 edges after re-enable.
  task automatic test_tick_en_freeze();
    tick_t e;
    e.at_edge = 432; e.phase = 2'd1; e.us = 1'b0; exp_q.push_back(e);
    e.at_edge = 457; e.phase = 2'd2; e.us = 1'b0; exp_q.push_back(e);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        e.at_edge = 492; e.phase = 2'd3; e.us = 1'b0; exp_q.push_back(e);
        e.at_edge = 517; e.phase = 2'd0; e.us = 1'b1; exp_q.push_back(e);
        e.at_edge = 542; e.phase = 2'd1; e.us = 1'b0; exp_q.push_back(e);
      end
      while (cyc - t0 < ((pass == 0) ? 469 : 542)) begin
        @(negedge clk);
        if (tick_q_a) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL freeze_extra edge %0d: TICK_Q=1 required 0", cyc - t0);
          end else begin
            e = exp_q.pop_front();
            if (cyc - t0 !== e.at_edge || phase_a !== e.phase || tick_us_a !== e.us) begin
              errors++;
              $display("FAIL freeze_tick edge %0d PHASE=%0d TICK_US=%b required edge %0d PHASE=%0d TICK_US=%b",
                       cyc - t0, phase_a, tick_us_a, e.at_edge, e.phase, e.us);
            end
          end
        end
      end
      if (pass == 0) begin
        en_a = 1'b0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          checks++;
          if (tick_q_a !== 1'b0 || tick_us_a !== 1'b0 || phase_a !== 2'd2) begin
            errors++;
            $display("FAIL freeze_hold edge %0d: TICK_Q=%b TICK_US=%b PHASE=%0d required 0 0 2",
                     cyc - t0, tick_q_a, tick_us_a, phase_a);
          end
        end
        en_a = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL freeze_missing: %0d pending required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    checks++;
    if (tick_q_a !== 1'b1 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: TICK_Q=%b READY=%b required 1 1", tick_q_a, ready_a);
    end
    #2 rst_a = 1'b1;
    #1;
    checks++;
    if ({fab_reset_a, ready_a, tick_q_a, tick_us_a, phase_a} !== 6'b100000) begin
      errors++;
      $display("FAIL async_reset: {FAB_RESET,READY,TICK_Q,TICK_US,PHASE}=%b required 100000",
               {fab_reset_a, ready_a, tick_q_a, tick_us_a, phase_a});
    end
  endtask

  // Lock dropped 3 cycles at stable count 500; READY needs a fresh full window (edge 1534).
  task automatic test_lock_loss_stabilize();
    int e;
    @(negedge clk);
    rst_b = 1'b0;
    t1 = cyc;
    while (cyc - t1 < 1534) begin
      @(negedge clk);
      e = cyc - t1;
      checks++;
      if (ready_b !== (e >= 1534) || fab_reset_b !== (e < 1534)) begin
        errors++;
        $display("FAIL stabilize edge %0d: READY=%b FAB_RESET=%b required READY=%b FAB_RESET=%b",
                 e, ready_b, fab_reset_b, (e >= 1534), (e < 1534));
      end
      if (e == 503) lock_b = 1'b0;
      if (e == 506) lock_b = 1'b1;
    end
  endtask

  // Lock falls 3 edges before the wrap due at edge 1584; the wrap must be suppressed.
  task automatic test_lock_drop_run();
    tick_t t;
    int e;
    t.at_edge = 1559; t.phase = 2'd1; t.us = 1'b0; exp_q.push_back(t);
    while (cyc - t1 < 1586) begin
      @(negedge clk);
      e = cyc - t1;
      if (tick_q_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drop_extra edge %0d: TICK_Q=1 required 0", e);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.at_edge || phase_b !== t.phase || tick_us_b !== t.us) begin
            errors++;
            $display("FAIL drop_tick edge %0d PHASE=%0d TICK_US=%b required edge %0d PHASE=%0d TICK_US=%b",
                     e, phase_b, tick_us_b, t.at_edge, t.phase, t.us);
          end
        end
      end
      if (e == 1583) begin
        checks++;
        if (ready_b !== 1'b1 || fab_reset_b !== 1'b0 || phase_b !== 2'd1) begin
          errors++;
          $display("FAIL drop_before: READY=%b FAB_RESET=%b PHASE=%0d required 1 0 1",
                   ready_b, fab_reset_b, phase_b);
        end
      end
      if (e == 1584) begin
        checks++;
        if ({fab_reset_b, ready_b, tick_q_b, tick_us_b, phase_b} !== 6'b100000) begin
          errors++;
          $display("FAIL drop_after: {FAB_RESET,READY,TICK_Q,TICK_US,PHASE}=%b required 100000",
                   {fab_reset_b, ready_b, tick_q_b, tick_us_b, phase_b});
        end
      end
      if (e == 1581) lock_b = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_missing: %0d pending required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_lock_ignore();
    test_ticks();
    test_tick_en_freeze();
    test_reset_mid_run();
    test_lock_loss_stabilize();
    test_lock_drop_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
